// File: rtl/dco_bank.sv
// Bank of CHANNELS programmable digital oscillators (square wave or single-cycle pulse).
// Latency: outputs are registered; a terminal count shows on dco_out/tick one cycle after it is reached.
// Backpressure: none; i_ena low freezes every channel and config writes are accepted every cycle.
module dco_bank #(
  parameter int CHANNELS       = 4,
  parameter int CNT_W          = 8,
  parameter int DEFAULT_PERIOD = 50,
  localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ena,
  input  logic                i_cfg_we,
  input  logic [CH_W-1:0]     i_cfg_ch,
  input  logic [CNT_W-1:0]    i_cfg_period,
  input  logic                i_cfg_mode,
  input  logic                i_sync,
  output logic [CHANNELS-1:0] o_dco_out,
  output logic [CHANNELS-1:0] o_tick
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic             r_mode;
    logic             r_dco;
    logic             r_tick;

    logic w_wr;
    logic w_mode_chg;
    logic w_term;

    // An out-of-range channel index never matches any g, so such writes are dropped.
    assign w_wr       = i_cfg_we && (i_cfg_ch == CH_W'(g));
    assign w_mode_chg = w_wr && (i_cfg_mode != r_mode);
    // ">=" rather than "==" so a period lowered below the running count ends the phase at once.
    assign w_term     = (r_cnt >= r_period);

    // Per-channel config, counter and output state; the counter uses the period held before this edge.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_cnt    <= '0;
        r_period <= CNT_W'(DEFAULT_PERIOD);
        r_mode   <= 1'b0;
        r_dco    <= 1'b0;
        r_tick   <= 1'b0;
      end else begin
        if (w_wr) begin
          r_period <= i_cfg_period;
          r_mode   <= i_cfg_mode;
        end
        if (i_sync) begin
          r_cnt  <= '0;
          r_dco  <= 1'b0;
          r_tick <= 1'b0;
        end else if (!i_ena) begin
          r_tick <= 1'b0;
          if (w_mode_chg) begin
            r_dco <= 1'b0;
          end
        end else if (r_period == '0) begin
          r_cnt  <= '0;
          r_dco  <= 1'b0;
          r_tick <= 1'b0;
        end else if (w_term) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
          if (w_mode_chg) begin
            r_dco <= 1'b0;
          end else if (r_mode) begin
            r_dco <= 1'b1;
          end else begin
            r_dco <= ~r_dco;
          end
        end else begin
          r_cnt  <= r_cnt + CNT_W'(1);
          r_tick <= 1'b0;
          // Pulse mode is high only right after a terminal; a mode change always lands low.
          if (w_mode_chg || r_mode) begin
            r_dco <= 1'b0;
          end
        end
      end
    end

    assign o_dco_out[g] = r_dco;
    assign o_tick[g]    = r_tick;
  end

endmodule

// File: tb/tb_dco_bank.sv
// Self-checking bench for dco_bank: hand-computed table, directed corner sequences,
// then randomized traffic compared cycle by cycle against a behavioural model.
module tb_dco_bank;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int DP = 50;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [W-1:0]  cfg_period = '0;
  logic          cfg_mode = 1'b0;
  logic          sync = 1'b0;
  logic [CH-1:0] dco;
  logic [CH-1:0] tick;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int m_cnt [CH];
  int m_per [CH];
  bit m_mode[CH];
  bit m_dco [CH];
  bit m_tick[CH];

  always #5 clk = ~clk;

  dco_bank #(
    .CHANNELS(CH),
    .CNT_W(W),
    .DEFAULT_PERIOD(DP)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_ena       (ena),
    .i_cfg_we    (cfg_we),
    .i_cfg_ch    (cfg_ch),
    .i_cfg_period(cfg_period),
    .i_cfg_mode  (cfg_mode),
    .i_sync      (sync),
    .o_dco_out   (dco),
    .o_tick      (tick)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // One clock edge of the reference behaviour, from the inputs present at that edge.
  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      bit wr;
      bit mode_changes;
      int per_before;
      bit mode_before;
      wr           = cfg_we && (int'(cfg_ch) == c);
      mode_changes = wr && (cfg_mode != m_mode[c]);
      per_before   = m_per[c];
      mode_before  = m_mode[c];
      if (!rst_n) begin
        m_cnt[c] = 0; m_per[c] = DP; m_mode[c] = 0; m_dco[c] = 0; m_tick[c] = 0;
      end else begin
        if (wr) begin
          m_per[c]  = int'(cfg_period);
          m_mode[c] = cfg_mode;
        end
        if (sync) begin
          m_cnt[c] = 0; m_dco[c] = 0; m_tick[c] = 0;
        end else if (!ena) begin
          m_tick[c] = 0;
          if (mode_changes) m_dco[c] = 0;
        end else if (per_before == 0) begin
          m_cnt[c] = 0; m_dco[c] = 0; m_tick[c] = 0;
        end else if (m_cnt[c] >= per_before) begin
          m_cnt[c]  = 0;
          m_tick[c] = 1;
          if (mode_changes)     m_dco[c] = 0;
          else if (mode_before) m_dco[c] = 1;
          else                  m_dco[c] = !m_dco[c];
        end else begin
          m_cnt[c]  = m_cnt[c] + 1;
          m_tick[c] = 0;
          if (mode_changes || mode_before) m_dco[c] = 0;
        end
      end
    end
  endtask

  // Advance one edge, step the model, and compare both output vectors just after the edge.
  task automatic cyc();
    logic [CH-1:0] ed;
    logic [CH-1:0] et;
    @(posedge clk);
    model_step();
    #1;
    for (int c = 0; c < CH; c++) begin
      ed[c] = m_dco[c];
      et[c] = m_tick[c];
    end
    chk("model_dco", 32'(dco), 32'(ed));
    chk("model_tick", 32'(tick), 32'(et));
  endtask

  task automatic idle_inputs();
    cfg_we = 0; sync = 0; cfg_ch = '0; cfg_period = '0; cfg_mode = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0; ena = 1;
    cyc();
    rst_n = 1;
  endtask

  typedef struct {
    int p;
    bit mode;
    int n;
    int exp_ticks;
    int exp_highs;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int ticks;
    int highs;
    logic d_before;

    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0; m_per[c] = DP; m_mode[c] = 0; m_dco[c] = 0; m_tick[c] = 0;
    end

    // Reset state
    rst_n = 0;
    #1;
    cyc();
    cyc();
    chk("reset_dco", 32'(dco), 32'(0));
    chk("reset_tick", 32'(tick), 32'(0));
    rst_n = 1; ena = 1;

    // Table: write ch0 together with sync, then count ticks and high cycles over n edges.
    tbl[0] = '{p: 3,   mode: 0, n: 24,  exp_ticks: 6, exp_highs: 12};
    tbl[1] = '{p: 4,   mode: 1, n: 25,  exp_ticks: 5, exp_highs: 5};
    tbl[2] = '{p: 0,   mode: 0, n: 10,  exp_ticks: 0, exp_highs: 0};
    tbl[3] = '{p: 1,   mode: 0, n: 10,  exp_ticks: 5, exp_highs: 5};
    tbl[4] = '{p: 255, mode: 0, n: 600, exp_ticks: 2, exp_highs: 256};
    tbl[5] = '{p: 10,  mode: 1, n: 33,  exp_ticks: 3, exp_highs: 3};
    for (int r = 0; r < 6; r++) begin
      cfg_we = 1; cfg_ch = 2'd0; cfg_period = W'(tbl[r].p); cfg_mode = tbl[r].mode; sync = 1;
      cyc();
      chk($sformatf("tbl%0d_sync_dco", r), 32'(dco), 32'(0));
      idle_inputs();
      ticks = 0; highs = 0;
      for (int j = 0; j < tbl[r].n; j++) begin
        cyc();
        ticks += int'(tick[0]);
        highs += int'(dco[0]);
      end
      chk($sformatf("tbl%0d_ticks", r), 32'(ticks), 32'(tbl[r].exp_ticks));
      chk($sformatf("tbl%0d_highs", r), 32'(highs), 32'(tbl[r].exp_highs));
    end

    // Period lowered below the running count; also first terminal after release.
    do_reset();
    for (int e = 1; e <= 40; e++) cyc();
    cfg_we = 1; cfg_ch = 2'd0; cfg_period = 8'd10; cfg_mode = 0;
    for (int e = 41; e <= 53; e++) begin
      cyc();
      idle_inputs();
      if (e == 41) chk("lower_no_tick_on_write", 32'(tick[0]), 32'(0));
      if (e == 42) chk("lower_tick_next", 32'(tick[0]), 32'(1));
      if (e == 42) chk("lower_dco_high", 32'(dco[0]), 32'(1));
      if (e == 52) chk("lower_no_tick_early", 32'(tick[0]), 32'(0));
      if (e == 53) chk("lower_tick_11", 32'(tick[0]), 32'(1));
      if (e == 50) chk("first_tick_not_early", 32'(tick[1]), 32'(0));
      if (e == 51) chk("first_tick_ch1", 32'(tick[1]), 32'(1));
      if (e == 51) chk("first_tick_all", 32'(tick), 32'(4'b1110));
    end

    // Enable dropped for 7 cycles mid-phase.
    do_reset();
    for (int e = 1; e <= 20; e++) cyc();
    ena = 0;
    ticks = 0;
    d_before = dco[0];
    for (int e = 21; e <= 27; e++) begin
      cyc();
      ticks += int'(tick != 0);
    end
    chk("freeze_no_tick", 32'(ticks), 32'(0));
    chk("freeze_dco_held", 32'(dco[0]), 32'(d_before));
    ena = 1;
    for (int e = 28; e <= 58; e++) begin
      cyc();
      if (e == 57) chk("freeze_late_not_yet", 32'(tick[0]), 32'(0));
      if (e == 58) chk("freeze_late_tick", 32'(tick[0]), 32'(1));
    end

    // Disabled channel, then reset mid-phase brings back default toggling.
    cfg_we = 1; cfg_ch = 2'd3; cfg_period = 8'd0;
    cyc();
    idle_inputs();
    highs = 0;
    for (int e = 0; e < 60; e++) begin
      cyc();
      highs += int'(dco[3]) + int'(tick[3]);
    end
    chk("disabled_ch3_quiet", 32'(highs), 32'(0));
    do_reset();
    chk("reset_mid_phase_tick", 32'(tick), 32'(0));
    for (int e = 1; e <= 51; e++) cyc();
    chk("after_reset_all_toggle", 32'(dco), 32'(4'b1111));

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      int r;
      rst_n  = ($urandom_range(0, 299) != 0);
      ena    = ($urandom_range(0, 9) != 0);
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_ch = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 19);
      if (r == 0)      cfg_period = 8'd0;
      else if (r == 1) cfg_period = 8'd255;
      else             cfg_period = W'($urandom_range(1, 12));
      cfg_mode = 1'($urandom_range(0, 1));
      sync     = ($urandom_range(0, 49) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dco_bank.md
DCO_BANK -- requirements
Module: dco_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent oscillator channels (1..8).
REQ-002 Parameter CNT_W, default 8: period/counter width in bits.
REQ-003 Parameter DEFAULT_PERIOD, default 50: per-channel period after reset (must fit in CNT_W).
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on the rising clk edge.
REQ-006 ena  input  1  global run enable; low freezes all channels.
REQ-007 cfg_we  input  1  configuration write strobe, one write per cycle.
REQ-008 cfg_ch  input  clog2(CHANNELS) (min 1)  target channel of the write.
REQ-009 cfg_period  input  CNT_W  new period value for the target channel.
REQ-010 cfg_mode  input  1  new mode for the target channel: 0 = toggle (square wave), 1 = pulse.
REQ-011 sync  input  1  phase-realign strobe for all channels.
REQ-012 dco_out  output  CHANNELS  per-channel oscillator output, registered.
REQ-013 tick  output  CHANNELS  per-channel one-cycle terminal-count strobe, registered.

Function
REQ-014 Each channel SHALL hold period_q[CNT_W], mode_q, a counter cnt[CNT_W] and output dco_out[i].
REQ-015 On cfg_we=1, period_q and mode_q of channel cfg_ch SHALL update on that edge; cfg_ch >= CHANNELS SHALL be ignored.
REQ-016 A write SHALL NOT reset cnt; the new period applies from the next cycle.
REQ-017 Terminal condition SHALL be cnt >= period_q, so a period lowered below the current count terminates on the next active cycle (no wrap through 2^CNT_W).
REQ-018 With ena=1, period_q != 0 and no terminal: cnt <= cnt + 1.
REQ-019 On terminal: cnt <= 0 and tick[i] <= 1 for exactly that cycle.
REQ-020 In toggle mode, terminal SHALL invert dco_out[i]: high and low phases are each period_q+1 cycles; output period is 2*(period_q+1).
REQ-021 In pulse mode, dco_out[i] SHALL be 1 only in the cycle following a terminal and 0 otherwise; pulse spacing is period_q+1 cycles.
REQ-022 A mode change SHALL force dco_out[i] to 0 on the writing edge; cnt continues.
REQ-023 period_q = 0 SHALL disable the channel: cnt held at 0, dco_out[i] = 0, tick[i] = 0.
REQ-024 With ena=0, cnt, dco_out and mode/period behaviour SHALL freeze; tick SHALL be 0; cfg writes SHALL still be accepted.
REQ-025 sync=1 SHALL set every cnt to 0, every dco_out to 0 and every tick to 0 on that edge, regardless of ena.
REQ-026 If sync and cfg_we occur together, both SHALL take effect: the write lands and the counters clear.
REQ-027 Channels SHALL be fully independent apart from the shared ena, sync and configuration port.
REQ-028 Counter arithmetic SHALL be CNT_W bits unsigned; period_q = 2^CNT_W-1 SHALL be legal, giving 2^CNT_W cycles per phase.

Reset
REQ-029 While rst_n=0 at a clk edge: cnt <= 0, period_q <= DEFAULT_PERIOD, mode_q <= 0 (toggle), dco_out <= 0, tick <= 0 for all channels.
REQ-030 Reset SHALL take priority over sync, cfg_we and ena; reset mid-phase SHALL discard the phase with no glitch pulse on tick.
REQ-031 The first terminal after reset release with ena=1 SHALL occur DEFAULT_PERIOD+1 cycles after release.

Verification
REQ-032 Reset, ena=1, no writes -> every dco_out toggles every 51 cycles (period 102); tick pulses every 51 cycles, all channels in phase.
REQ-033 Write ch1 period=3 mode=0, ch2 period=4 mode=1 -> ch1 square wave of period 8; ch2 single-cycle high every 5 cycles; ch0 and ch3 unchanged.
REQ-034 ch0 at cnt=40, write period=10 -> terminal and toggle on the next cycle, then 11-cycle phases.
REQ-035 ena low for 7 cycles mid-phase -> outputs and counts frozen, no tick; the phase completes 7 cycles late.
REQ-036 sync asserted with channels out of phase -> all dco_out=0 and cnt=0 next cycle; subsequent edges aligned across equal-period channels.
REQ-037 Write period=0 to ch3, then rst_n low for one cycle mid-phase -> ch3 holds 0 until reset; after reset all channels resume DEFAULT_PERIOD toggling from 0.
